// File: rtl/fifo_rf_pkg.sv
// Shared types for the register-file FIFO: the operation decoded from
// the accepted push/pop pair each cycle.
package fifo_rf_pkg;

    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/fifo_rf_if.sv
// Producer/consumer bundle for fifo_rf: push and pop requests in,
// head word and occupancy flags out.
interface fifo_rf_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
);
    logic                  wr;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  rd;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  empty;
    logic                  full;
    logic [ADDR_WIDTH:0]   count;

    modport master (
        output wr, w_data, rd,
        input  r_data, empty, full, count
    );

    modport slave (
        input  wr, w_data, rd,
        output r_data, empty, full, count
    );
endinterface

// File: rtl/fifo_ctrl.sv
// Pointer and flag control for fifo_rf: tracks write/read pointers,
// occupancy count and empty/full, and qualifies the store write enable.
module fifo_ctrl
    import fifo_rf_pkg::*;
#(
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  rd,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic                  wr_en,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   count
);

    logic [ADDR_WIDTH-1:0] w_ptr, w_ptr_next, w_ptr_succ;
    logic [ADDR_WIDTH-1:0] r_ptr, r_ptr_next, r_ptr_succ;
    logic                  empty_next, full_next;
    logic [ADDR_WIDTH:0]   count_next;
    logic                  push_ok, pop_ok;
    fifo_op_e              op;

    // A push while full is still accepted when a pop frees the head slot.
    assign push_ok    = wr & (~full | rd);
    assign pop_ok     = rd & ~empty;
    assign op         = fifo_op_e'({push_ok, pop_ok});
    assign w_ptr_succ = w_ptr + 1'b1;
    assign r_ptr_succ = r_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            w_ptr <= '0;
            r_ptr <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
            count <= '0;
        end else begin
            w_ptr <= w_ptr_next;
            r_ptr <= r_ptr_next;
            empty <= empty_next;
            full  <= full_next;
            count <= count_next;
        end
    end

    always_comb begin
        w_ptr_next = w_ptr;
        r_ptr_next = r_ptr;
        empty_next = empty;
        full_next  = full;
        count_next = count;
        case (op)
            OP_PUSH: begin
                w_ptr_next = w_ptr_succ;
                empty_next = 1'b0;
                full_next  = (w_ptr_succ == r_ptr);
                count_next = count + 1'b1;
            end
            OP_POP: begin
                r_ptr_next = r_ptr_succ;
                full_next  = 1'b0;
                empty_next = (r_ptr_succ == w_ptr);
                count_next = count - 1'b1;
            end
            OP_BOTH: begin
                w_ptr_next = w_ptr_succ;
                r_ptr_next = r_ptr_succ;
            end
            default: begin
            end
        endcase
    end

    // Reset wins over a same-cycle push, so the store is left untouched too.
    assign wr_en  = push_ok & ~reset;
    assign w_addr = w_ptr;
    assign r_addr = r_ptr;

endmodule

// File: rtl/fifo_rf.sv
// Synchronous first-word-fall-through FIFO: register-file store written at
// the write pointer, head word read combinationally at the read pointer.
module fifo_rf #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
) (
    input  logic     clk,
    input  logic     reset,
    fifo_rf_if.slave bus
);

    logic [DATA_WIDTH-1:0] store [0:2**ADDR_WIDTH-1];
    logic [ADDR_WIDTH-1:0] w_addr, r_addr;
    logic                  wr_en;

    fifo_ctrl #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ctrl (
        .clk    (clk),
        .reset  (reset),
        .wr     (bus.wr),
        .rd     (bus.rd),
        .w_addr (w_addr),
        .r_addr (r_addr),
        .wr_en  (wr_en),
        .empty  (bus.empty),
        .full   (bus.full),
        .count  (bus.count)
    );

    // Storage is deliberately not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            store[w_addr] <= bus.w_data;
        end
    end

    assign bus.r_data = store[r_addr];

endmodule

// File: tb/tb_fifo_rf.sv
// Directed testbench for fifo_rf: stimulus queues expected words, a negedge
// monitor checks popped data and occupancy flags against a count model.
module tb_fifo_rf;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 2;
    localparam int DEPTH      = 2**ADDR_WIDTH;

    logic clk;
    logic reset;

    fifo_rf_if #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

    fifo_rf #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [DATA_WIDTH-1:0] exp_q [$];
    int  m_count;
    bit  mon_en;
    int  n_checks;
    int  n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Drives one cycle of requests and advances the occupancy model.
    task automatic applyStimulus(input logic w, input logic [DATA_WIDTH-1:0] d, input logic r);
        bit push_ok, pop_ok;
        bus.wr     = w;
        bus.w_data = d;
        bus.rd     = r;
        push_ok = w && (m_count < DEPTH || r);
        pop_ok  = r && (m_count > 0);
        if (push_ok) exp_q.push_back(d);
        @(posedge clk);
        m_count = m_count + int'(push_ok) - int'(pop_ok);
        #1;
        bus.wr = 1'b0;
        bus.rd = 1'b0;
    endtask

    task automatic resetDut();
        reset  = 1'b1;
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        @(posedge clk);
        m_count = 0;
        exp_q.delete();
        #1;
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en && !reset) begin
            checkOutput("count", 32'(bus.count), 32'(m_count));
            checkOutput("empty", 32'(bus.empty), 32'(m_count == 0));
            checkOutput("full",  32'(bus.full),  32'(m_count == DEPTH));
            if (bus.rd && m_count > 0) begin
                if (exp_q.size() == 0) begin
                    checkOutput("pop_unexpected", 32'(bus.r_data), 32'hFFFF_FFFF);
                end else begin
                    checkOutput("r_data", 32'(bus.r_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        m_count    = 0;
        mon_en     = 0;
        bus.w_data = '0;
        resetDut();
        mon_en = 1;

        // Reset mid-traffic
        applyStimulus(1, 8'h01, 0);
        applyStimulus(1, 8'h02, 0);
        applyStimulus(1, 8'h03, 0);
        resetDut();
        @(negedge clk);
        checkOutput("reset_count", 32'(bus.count), 32'd0);
        checkOutput("reset_empty", 32'(bus.empty), 32'd1);
        checkOutput("reset_full",  32'(bus.full),  32'd0);
        #1;
        applyStimulus(1, 8'hA5, 0);
        applyStimulus(0, 8'h00, 1);

        // Fill, overflow attempt, drain
        applyStimulus(1, 8'h11, 0);
        applyStimulus(1, 8'h22, 0);
        applyStimulus(1, 8'h33, 0);
        applyStimulus(1, 8'h44, 0);
        applyStimulus(1, 8'h55, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 8'h00, 1);
        applyStimulus(0, 8'h00, 0);

        // Underflow attempts then a push
        for (int i = 0; i < 3; i++) applyStimulus(0, 8'h00, 1);
        applyStimulus(1, 8'h7E, 0);
        applyStimulus(0, 8'h00, 1);

        // Push and pop together while empty
        applyStimulus(1, 8'h3C, 1);
        applyStimulus(0, 8'h00, 0);
        applyStimulus(0, 8'h00, 1);

        // Push and pop together while full
        applyStimulus(1, 8'h01, 0);
        applyStimulus(1, 8'h02, 0);
        applyStimulus(1, 8'h03, 0);
        applyStimulus(1, 8'h04, 0);
        applyStimulus(1, 8'h05, 1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 8'h00, 1);

        // Pointer wrap-around with alternating push/pop
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 8'(8'h80 + i), 0);
            applyStimulus(0, 8'h00, 1);
        end
        applyStimulus(0, 8'h00, 0);
        @(negedge clk);
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
